// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - single-clock FIFO: show-ahead option, programmable af/ae, level, flush
// Optional statistics outputs hwm/ovf_cnt/unf_cnt are built when FIFO_SYNC_PROG_STATS_EN is defined.
module fifo_sync_prog #(
  parameter int ADDRWIDTH = 5,
  parameter int DATAWIDTH = 18,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 flush,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 we,
  output logic                 full,
  output logic                 af,
  output logic                 ovf,
  output logic [DATAWIDTH-1:0] rd_data,
  input  logic                 re,
  output logic                 ne,
  output logic                 ae,
  output logic                 unf,
  output logic [ADDRWIDTH:0]   level,
  input  logic [ADDRWIDTH:0]   af_thresh,
  input  logic [ADDRWIDTH:0]   ae_thresh
`ifdef FIFO_SYNC_PROG_STATS_EN
  ,
  output logic [ADDRWIDTH:0]   hwm,
  output logic [15:0]          ovf_cnt,
  output logic [15:0]          unf_cnt
`endif
);

  localparam int                 DEPTH      = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] DEPTH_L    = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0] ONE        = {{ADDRWIDTH{1'b0}}, 1'b1};
  localparam bit                 SHOW_AHEAD = (FWFT != 0);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [ADDRWIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDRWIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDRWIDTH:0]   level_q, level_d;
  logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
  logic                 out_vld_q, out_vld_d;
  logic [ADDRWIDTH:0]   mem_cnt;
  logic                 active, wr_acc, rd_acc, mem_rd;

  // Flush wins over both requests; enable low freezes everything.
  assign active  = enable && !flush;
  assign full    = (level_q == DEPTH_L);
  assign ne      = SHOW_AHEAD ? out_vld_q : (level_q != '0);
  assign af      = (level_q >= af_thresh);
  assign ae      = (level_q <= ae_thresh);
  assign wr_acc  = active && we && !full;
  assign rd_acc  = active && re && ne;
  assign ovf     = !reset && active && we && full;
  assign unf     = !reset && active && re && !ne;
  assign mem_cnt = wr_ptr_q - rd_ptr_q;
  assign level   = level_q;
  assign rd_data = rd_data_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    out_vld_d = out_vld_q;
    mem_rd    = 1'b0;
    if (enable && flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      out_vld_d = 1'b0;
    end else if (enable) begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ONE;
      end
      if (SHOW_AHEAD) begin
        // Refill the output word whenever it is empty or being popped this cycle.
        mem_rd = (mem_cnt != '0) && (!out_vld_q || rd_acc);
        if (mem_rd) begin
          rd_data_d = mem_q[rd_ptr_q[ADDRWIDTH-1:0]];
          rd_ptr_d  = rd_ptr_q + ONE;
          out_vld_d = 1'b1;
        end else if (rd_acc) begin
          out_vld_d = 1'b0;
        end
      end else if (rd_acc) begin
        rd_data_d = mem_q[rd_ptr_q[ADDRWIDTH-1:0]];
        rd_ptr_d  = rd_ptr_q + ONE;
      end
    end
    level_d = (wr_ptr_d - rd_ptr_d) + {{ADDRWIDTH{1'b0}}, out_vld_d};
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[ADDRWIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
      out_vld_q <= out_vld_d;
    end
  end

`ifdef FIFO_SYNC_PROG_STATS_EN
  logic [ADDRWIDTH:0] hwm_q, hwm_d;
  logic [15:0]        ovf_cnt_q, ovf_cnt_d;
  logic [15:0]        unf_cnt_q, unf_cnt_d;

  always_comb begin
    hwm_d     = hwm_q;
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (enable && flush) begin
      hwm_d = '0;
    end else if (level_d > hwm_q) begin
      hwm_d = level_d;
    end
    if (ovf && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
    if (unf && (unf_cnt_q != 16'hFFFF)) begin
      unf_cnt_d = unf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hwm_q     <= '0;
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      hwm_q     <= hwm_d;
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  assign hwm     = hwm_q;
  assign ovf_cnt = ovf_cnt_q;
  assign unf_cnt = unf_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb/tb_fifo_sync_prog.sv - self-checking bench for fifo_sync_prog, registered-read and show-ahead instances
module tb_fifo_sync_prog;

  localparam int AW    = 3;
  localparam int DW    = 18;
  localparam int DEPTH = 1 << AW;

  logic          clk, reset, enable, flush, we, re;
  logic [DW-1:0] wr_data;
  logic [AW:0]   af_thresh, ae_thresh;

  logic          full0, af0, ovf0, ne0, ae0, unf0;
  logic [DW-1:0] rd_data0;
  logic [AW:0]   level0;
  logic          full1, af1, ovf1, ne1, ae1, unf1;
  logic [DW-1:0] rd_data1;
  logic [AW:0]   level1;
`ifdef FIFO_SYNC_PROG_STATS_EN
  logic [AW:0]   hwm0, hwm1;
  logic [15:0]   ovf_cnt0, unf_cnt0, ovf_cnt1, unf_cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] last_exp;
  bit            last_rd_ok;

  fifo_sync_prog #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .FWFT(0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .wr_data(wr_data), .we(we), .full(full0), .af(af0), .ovf(ovf0),
    .rd_data(rd_data0), .re(re), .ne(ne0), .ae(ae0), .unf(unf0),
    .level(level0), .af_thresh(af_thresh), .ae_thresh(ae_thresh)
`ifdef FIFO_SYNC_PROG_STATS_EN
    , .hwm(hwm0), .ovf_cnt(ovf_cnt0), .unf_cnt(unf_cnt0)
`endif
  );

  fifo_sync_prog #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .FWFT(1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .wr_data(wr_data), .we(we), .full(full1), .af(af1), .ovf(ovf1),
    .rd_data(rd_data1), .re(re), .ne(ne1), .ae(ae1), .unf(unf1),
    .level(level1), .af_thresh(af_thresh), .ae_thresh(ae_thresh)
`ifdef FIFO_SYNC_PROG_STATS_EN
    , .hwm(hwm1), .ovf_cnt(ovf_cnt1), .unf_cnt(unf_cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference model: q0 tracks the registered-read FIFO; q1 gets writes for the show-ahead FIFO.
  task automatic tick();
    bit wr_ok, rd_ok;
    wr_ok = enable && !flush && we && (q0.size() < DEPTH);
    rd_ok = enable && !flush && re && (q0.size() > 0);
    if (enable && flush) begin
      q0.delete();
      q1.delete();
    end
    last_rd_ok = rd_ok;
    if (rd_ok) last_exp = q0.pop_front();
    if (wr_ok) q0.push_back(wr_data);
    if (enable && !flush && we && (q1.size() < DEPTH)) q1.push_back(wr_data);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; flush = 1'b0; we = 1'b0; re = 1'b0;
    wr_data = '0; af_thresh = 4'd8; ae_thresh = 4'd0;
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; flush = 1'b0; we = 1'b0; re = 1'b0;
    wr_data = '0; af_thresh = 4'd0; ae_thresh = 4'd0;
    #3;
    checks++;
    if ({full0, ne0, ovf0, unf0, ae0, af0} !== 6'b000011) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000011", {full0, ne0, ovf0, unf0, ae0, af0});
    end
    checks++;
    if (level0 !== 4'd0 || rd_data0 !== '0 || level1 !== 4'd0 || ne1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_level got=%0d/%0h/%0d/%b exp=0/0/0/0", level0, rd_data0, level1, ne1);
    end
    af_thresh = 4'd8;
    #1;
    checks++;
    if (af0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_af_thresh8 got=%b exp=0", af0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_fill_ovf();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      we = 1'b1; wr_data = DW'(i);
      tick();
      checks++;
      if (level0 !== 4'(i)) begin
        failures++;
        $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, level0, i);
      end
    end
    checks++;
    if (full0 !== 1'b1 || ne0 !== 1'b1) begin
      failures++;
      $display("FAIL fill_full got=%b%b exp=11", full0, ne0);
    end
    wr_data = 18'h9; #1;
    checks++;
    if (ovf0 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_pulse got=%b exp=1", ovf0);
    end
    tick();
    we = 1'b0; #1;
    checks++;
    if (ovf0 !== 1'b0 || level0 !== 4'd8) begin
      failures++;
      $display("FAIL ovf_after got=%b/%0d exp=0/8", ovf0, level0);
    end
    we = 1'b1; re = 1'b1; wr_data = 18'hAA; #1;
    checks++;
    if (ovf0 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_we_re_full got=%b exp=1", ovf0);
    end
    tick();
    we = 1'b0;
    checks++;
    if (level0 !== 4'd7 || rd_data0 !== last_exp) begin
      failures++;
      $display("FAIL we_re_full got=%0d/%0h exp=7/%0h", level0, rd_data0, last_exp);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      tick();
      checks++;
      if (rd_data0 !== last_exp) begin
        failures++;
        $display("FAIL drain_data i=%0d got=%0h exp=%0h", i, rd_data0, last_exp);
      end
    end
    re = 1'b0;
    checks++;
    if (ne0 !== 1'b0 || level0 !== 4'd0) begin
      failures++;
      $display("FAIL drain_empty got=%b/%0d exp=0/0", ne0, level0);
    end
`ifdef FIFO_SYNC_PROG_STATS_EN
    checks++;
    if (ovf_cnt0 !== 16'd2 || hwm0 !== 4'd8) begin
      failures++;
      $display("FAIL stats_ovf got=%0d/%0d exp=2/8", ovf_cnt0, hwm0);
    end
`endif
  endtask

  task automatic test_fwft_single();
    logic [DW-1:0] e;
    do_reset();
    we = 1'b1; wr_data = 18'h2A;
    tick();
    we = 1'b0;
    checks++;
    if (ne1 !== 1'b0 || level1 !== 4'd1) begin
      failures++;
      $display("FAIL fwft_edgeN got=%b/%0d exp=0/1", ne1, level1);
    end
    tick();
    checks++;
    if (ne1 !== 1'b1 || rd_data1 !== q1[0]) begin
      failures++;
      $display("FAIL fwft_edgeN1 got=%b/%0h exp=1/%0h", ne1, rd_data1, q1[0]);
    end
    re = 1'b1;
    e = q1.pop_front();
    tick();
    re = 1'b0;
    checks++;
    if (ne1 !== 1'b0 || level1 !== 4'd0 || rd_data1 !== e) begin
      failures++;
      $display("FAIL fwft_pop got=%b/%0d/%0h exp=0/0/%0h", ne1, level1, rd_data1, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; wr_data = DW'(18'h100 + i);
      tick();
    end
    we = 1'b0;
    tick();
    checks++;
    if (full1 !== 1'b1 || level1 !== 4'd8) begin
      failures++;
      $display("FAIL fwft_full got=%b/%0d exp=1/8", full1, level1);
    end
    re = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      e = q1.pop_front();
      checks++;
      if (ne1 !== 1'b1 || rd_data1 !== e) begin
        failures++;
        $display("FAIL b2b_data i=%0d got=%b/%0h exp=1/%0h", i, ne1, rd_data1, e);
      end
      tick();
    end
    re = 1'b0;
    checks++;
    if (ne1 !== 1'b0 || level1 !== 4'd0) begin
      failures++;
      $display("FAIL b2b_empty got=%b/%0d exp=0/0", ne1, level1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; wr_data = DW'(18'h10 + i);
      tick();
    end
    re = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = DW'(18'h200 + i);
      tick();
      checks++;
      if (level0 !== 4'd4 || rd_data0 !== last_exp) begin
        failures++;
        $display("FAIL wrap i=%0d got=%0d/%0h exp=4/%0h", i, level0, rd_data0, last_exp);
      end
    end
    we = 1'b0; re = 1'b0;
  endtask

  task automatic test_thresh();
    do_reset();
    af_thresh = 4'd6; ae_thresh = 4'd1; #1;
    checks++;
    if ({af0, ae0} !== 2'b01) begin
      failures++;
      $display("FAIL thresh_empty got=%b exp=01", {af0, ae0});
    end
    for (int k = 1; k <= 6; k++) begin
      we = 1'b1; wr_data = DW'(k);
      tick();
      checks++;
      if ({af0, ae0} !== {(k >= 6), (k <= 1)}) begin
        failures++;
        $display("FAIL thresh_fill k=%0d got=%b exp=%b", k, {af0, ae0}, {(k >= 6), (k <= 1)});
      end
    end
    we = 1'b0; af_thresh = 4'd7;
    tick();
    checks++;
    if (af0 !== 1'b0) begin
      failures++;
      $display("FAIL thresh_reprog got=%b exp=0", af0);
    end
    af_thresh = 4'd9;
    we = 1'b1;
    tick();
    tick();
    we = 1'b0;
    checks++;
    if (full0 !== 1'b1 || af0 !== 1'b0) begin
      failures++;
      $display("FAIL thresh_above_depth got=%b/%b exp=1/0", full0, af0);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (unf0 !== 1'b1) begin
        failures++;
        $display("FAIL unf_pulse i=%0d got=%b exp=1", i, unf0);
      end
      tick();
      checks++;
      if (level0 !== 4'd0 || ne0 !== 1'b0) begin
        failures++;
        $display("FAIL unf_no_move i=%0d got=%0d/%b exp=0/0", i, level0, ne0);
      end
    end
    enable = 1'b0; #1;
    checks++;
    if (unf0 !== 1'b0) begin
      failures++;
      $display("FAIL unf_disabled got=%b exp=0", unf0);
    end
    tick();
    enable = 1'b1; re = 1'b0;
`ifdef FIFO_SYNC_PROG_STATS_EN
    checks++;
    if (unf_cnt0 !== 16'd3) begin
      failures++;
      $display("FAIL stats_unf got=%0d exp=3", unf_cnt0);
    end
`endif
  endtask

  task automatic test_flush_reset();
    logic [DW-1:0] held;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      we = 1'b1; wr_data = DW'(18'h30 + i);
      tick();
    end
    we = 1'b0; re = 1'b1;
    tick();
    held = last_exp;
    flush = 1'b1; we = 1'b1; re = 1'b1; wr_data = 18'h3F; #1;
    checks++;
    if ({ovf0, unf0} !== 2'b00 || level0 !== 4'd5) begin
      failures++;
      $display("FAIL flush_cycle got=%b/%0d exp=00/5", {ovf0, unf0}, level0);
    end
    tick();
    flush = 1'b0; we = 1'b0; re = 1'b0;
    checks++;
    if (level0 !== 4'd0 || ne0 !== 1'b0 || rd_data0 !== held || level1 !== 4'd0 || ne1 !== 1'b0) begin
      failures++;
      $display("FAIL flush_after got=%0d/%b/%0h exp=0/0/%0h", level0, ne0, rd_data0, held);
    end
    we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = DW'(18'h50 + i);
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({full0, ne0, ovf0, unf0, ae0} !== 5'b00001 || level0 !== 4'd0 || rd_data0 !== '0) begin
      failures++;
      $display("FAIL async_reset0 got=%b/%0d/%0h exp=00001/0/0", {full0, ne0, ovf0, unf0, ae0}, level0, rd_data0);
    end
    checks++;
    if (ne1 !== 1'b0 || level1 !== 4'd0 || rd_data1 !== '0) begin
      failures++;
      $display("FAIL async_reset1 got=%b/%0d/%0h exp=0/0/0", ne1, level1, rd_data1);
    end
    we = 1'b0;
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_ovf();
    test_fwft_single();
    test_back_to_back();
    test_wrap();
    test_thresh();
    test_underflow();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
